// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: HDMI bring-up sequencer and raster timing generator.
// Holds the TMDS encoders in reset for STARTUP_CYC cycles after PLL lock.
// Then enables the output buffer and generates hs/vs/de, pixel coordinates and a frame pulse.
// Optional feature macro: HDMI_TIMING_PREFETCH_EN adds pix_req/req_x/req_y,
// a one-cycle look-ahead of de/x/y for the pixel source.
module hdmi_timing_ctrl #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   STARTUP_CYC = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pll_locked,
    input  logic        enable,
    output logic        hdmi_oen,
    output logic        enc_rst,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic [1:0]  state
`ifdef HDMI_TIMING_PREFETCH_EN
    ,
    output logic        pix_req,
    output logic [11:0] req_x,
    output logic [11:0] req_y
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Window bounds are kept 13 bits wide so a 4096 total still compares correctly.
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST     = 13'(V_TOTAL - 1);

    localparam int HOLD_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STARTUP_CYC - 1);

    // Reject timing sets that overflow the 12-bit counters or have an empty hold.
    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || STARTUP_CYC < 1 ||
            H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_param_check
            $error("hdmi_timing_ctrl: invalid timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        ENC_RST   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [11:0]       h_cnt;
    logic [11:0]       v_cnt;

    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        h_active;
    logic        v_active;
    logic        h_sync_win;
    logic        v_sync_win;
    logic        frame_end;
    logic        timing_live;
    logic        de_next;

    assign state = state_q;

    // Decode the raster position and whether the raster keeps running past this edge.
    always_comb begin
        h_ext       = {1'b0, h_cnt};
        v_ext       = {1'b0, v_cnt};
        h_active    = (h_ext < H_ACT_END);
        v_active    = (v_ext < V_ACT_END);
        h_sync_win  = (h_ext >= HS_START) && (h_ext < HS_END);
        v_sync_win  = (v_ext >= VS_START) && (v_ext < VS_END);
        frame_end   = (h_ext == H_LAST) && (v_ext == V_LAST);
        timing_live = (state_q == RUN) && pll_locked && !(frame_end && !enable);
        de_next     = timing_live && h_active && v_active;
    end

`ifdef HDMI_TIMING_PREFETCH_EN
    // Look-ahead request: mirrors the value de and x/y will take on the next edge.
    always_comb begin
        pix_req = de_next;
        req_x   = de_next ? h_cnt : 12'd0;
        req_y   = de_next ? v_cnt : 12'd0;
    end
`endif

    // Bring-up sequencer with registered output-enable and encoder reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            hdmi_oen <= 1'b0;
            enc_rst  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    hdmi_oen <= 1'b0;
                    enc_rst  <= 1'b1;
                    if (enable) begin
                        state_q <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    hdmi_oen <= 1'b0;
                    enc_rst  <= 1'b1;
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (pll_locked) begin
                        state_q  <= ENC_RST;
                        hold_cnt <= '0;
                    end
                end
                ENC_RST: begin
                    if (!pll_locked) begin
                        state_q <= WAIT_LOCK;
                    end else if (!enable) begin
                        state_q <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_q  <= RUN;
                        hdmi_oen <= 1'b1;
                        enc_rst  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!pll_locked) begin
                        state_q  <= WAIT_LOCK;
                        hdmi_oen <= 1'b0;
                        enc_rst  <= 1'b1;
                    end else if (!enable && frame_end) begin
                        state_q  <= IDLE;
                        hdmi_oen <= 1'b0;
                        enc_rst  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    hdmi_oen <= 1'b0;
                    enc_rst  <= 1'b1;
                end
            endcase
        end
    end

    // Raster counters advance only while the raster is live and sit at zero otherwise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (!timing_live) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (h_ext == H_LAST) begin
            h_cnt <= 12'd0;
            v_cnt <= (v_ext == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Timing outputs are registered one cycle behind the counters, inactive when not live.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= 12'd0;
            y           <= 12'd0;
            frame_start <= 1'b0;
        end else if (timing_live) begin
            hs          <= h_sync_win ? HS_POL : ~HS_POL;
            vs          <= v_sync_win ? VS_POL : ~VS_POL;
            de          <= de_next;
            x           <= de_next ? h_cnt : 12'd0;
            y           <= de_next ? v_cnt : 12'd0;
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end else begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= 12'd0;
            y           <= 12'd0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/hdmi_timing_ctrl.md
# hdmi_timing_ctrl

Video timing controller and HDMI bring-up sequencer that drives the TMDS encoder/serializer path behind `top`. After PLL lock it holds the encoder in reset for a fixed interval, then enables the HDMI output buffer. It then generates raster timing (hs/vs/de, pixel coordinates, frame pulse) for the encoder and pixel source. Loss of lock or a disable request shuts the output down in an orderly way.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 0 / 0, sync polarity (1 = active-high)
- STARTUP_CYC, 16, encoder reset hold cycles after lock (≥1)
- sys_clk  in  1  pixel clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  pixel PLL lock, already synchronous to sys_clk
- enable  in  1  request video output
- hdmi_oen  out  1  HDMI output enable; 1 only in RUN
- enc_rst  out  1  active-high reset to TMDS encoders
- hs, vs, de  out  1 each  registered raster timing
- x, y  out  12 each  pixel coordinates, valid when de=1; 0 otherwise
- frame_start  out  1  one-cycle pulse with the first de of each frame
- state  out  2  current FSM state, for debug

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL similar (525). Counters h_cnt and v_cnt are 12 bits. Parameter sums must be ≤4096; this is checked at elaboration.
- Line layout by h_cnt: [0,H_ACTIVE) active; then FP, then SYNC at [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP. Vertical layout by v_cnt uses the same order.
- de = h active AND v active. hs asserts (per HS_POL) across the full H sync window on every line. vs asserts across the full lines of V sync, changing at h_cnt=0.
- h_cnt wraps H_TOTAL-1→0 and increments v_cnt. v_cnt wraps V_TOTAL-1→0.
- FSM states, with `state` encoding:
  - IDLE=0: counters 0, enc_rst=1, hdmi_oen=0. If enable=1, go to WAIT_LOCK.
  - WAIT_LOCK=1: enc_rst=1. If pll_locked=1, go to ENC_RST and clear the hold counter. If enable=0, go to IDLE.
  - ENC_RST=2: enc_rst=1 for exactly STARTUP_CYC cycles, then go to RUN. If lock drops, go to WAIT_LOCK. If enable=0, go to IDLE.
  - RUN=3: enc_rst=0, hdmi_oen=1, counters run.
    - pll_locked=0: go to WAIT_LOCK the next cycle, counters clear, timing outputs go inactive.
    - enable=0: finish the current frame. Go to IDLE on the cycle after h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
    - enable re-asserted before the frame ends cancels the drain.
- Simultaneous lock loss and enable=0: lock loss wins, next state is WAIT_LOCK.
- Outside RUN: hs/vs are at their inactive level; de, x, y and frame_start are 0.

## Timing
- Reset values: state=IDLE, hdmi_oen=0, enc_rst=1, de=0, x=y=0, frame_start=0, hs=~HS_POL... inactive, vs inactive.
- Timing outputs are registered and lag the counters by 1 cycle. The first RUN cycle has h_cnt=v_cnt=0, so de, frame_start and x=y=0 appear on the second RUN cycle.
- hdmi_oen and enc_rst change on the same edge as the state register.
- enable→hdmi_oen latency with lock already high is 1 (IDLE→WAIT_LOCK) + 1 (→ENC_RST) + STARTUP_CYC cycles.
- Lock loss in RUN gives hdmi_oen=0 and enc_rst=1 one cycle after pll_locked samples low.

## Configuration
- HDMI_TIMING_PREFETCH_EN
  - Defined: adds output `pix_req` (1 bit). pix_req=1 exactly one cycle before each de=1 cycle; it is combinational from the counters, with 0 latency versus the next registered de. Adds outputs `req_x`/`req_y` (12 bits), which equal the x/y that the following cycle presents. All are 0 outside RUN and at reset.
  - Undefined: these ports and their logic do not exist. All other behaviour is identical.

## Test plan
- Reset and bring-up: release sys_rst_n with enable=1 and pll_locked=1 → hdmi_oen rises exactly 18 cycles later (default STARTUP_CYC). enc_rst falls on the same edge.
- Raster check, default parameters: count over 2 frames → 800 cycles per hs period with hs low for 96. 525 lines per vs period with vs low for 2 lines. 640×480 de cycles per frame. Last active pixel shows x=639, y=479.
- frame_start: exactly one pulse per 420000 cycles, coincident with de=1, x=0, y=0.
- Lock loss mid-line (h_cnt=300): drop pll_locked → next cycle hdmi_oen=0, enc_rst=1, de=0. Re-lock → 16-cycle hold, then the frame restarts at x=0, y=0.
- Graceful disable: deassert enable at line 100 → video continues to y=479 and vertical blanking finishes. Go to IDLE one cycle after the counters reach (799,524); hdmi_oen=0.
- With HDMI_TIMING_PREFETCH_EN: pix_req leads de by exactly 1 cycle on every active pixel. req_x=0 and req_y=0 one cycle before frame_start.
